ssd_entry_mux_driver: RTL and testbench

- Drives the two-digit seven-segment display and its single chip-select line from debounced keypad events.
- Captures keypad codes into two digit registers, alternating between them.
- Mode 0: shows the latest key on a manually selected digit. Mode 1: time-multiplexes both digits at a fixed refresh rate, with a blanking gap to stop ghosting.
- Sits between the keypad decoder / pulse detectors and the board pins `seg` / `chip_sel`.

---
 rtl/ssd_pkg.sv | 26 ++
 rtl/ssd_entry_mux_driver_refresh_fsm.sv | 45 ++++
 rtl/ssd_entry_mux_driver.sv | 97 +++++++++
 tb/tb_ssd_entry_mux_driver.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: display FSM states, blank glyph and hex-to-seven-segment decode
// shared by the seven-segment display blocks.
package ssd_pkg;
    typedef enum logic [1:0] {SHOW_D0, BLANK_D0, SHOW_D1, BLANK_D1} state_t;
    localparam logic [6:0] SEG_BLANK = 7'b0;
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b1111110;
            4'h1: hex_to_seg = 7'b0110000;
            4'h2: hex_to_seg = 7'b1101101;
            4'h3: hex_to_seg = 7'b1111001;
            4'h4: hex_to_seg = 7'b0110011;
            4'h5: hex_to_seg = 7'b1011011;
            4'h6: hex_to_seg = 7'b1011111;
            4'h7: hex_to_seg = 7'b1110000;
            4'h8: hex_to_seg = 7'b1111111;
            4'h9: hex_to_seg = 7'b1111011;
            4'hA: hex_to_seg = 7'b1110111;
            4'hB: hex_to_seg = 7'b0011111;
            4'hC: hex_to_seg = 7'b1001110;
            4'hD: hex_to_seg = 7'b0111101;
            4'hE: hex_to_seg = 7'b1001111;
            default: hex_to_seg = 7'b1000111;
        endcase
    endfunction
endpackage

// File: rtl/ssd_entry_mux_driver_refresh_fsm.sv
// ssd_refresh_fsm: slot counter and show/blank sequencer for two-digit multiplexing;
// held in SHOW_D0 with counter 0 while disabled.
module ssd_refresh_fsm
    import ssd_pkg::*;
#(
    parameter int SLOT = 50_000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    output state_t state,
    output logic   chip_sel_mux
);
    localparam int CW = $clog2(SLOT) < 1 ? 1 : $clog2(SLOT);
    localparam logic [CW-1:0] SHOW_END = CW'(SLOT - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(SLOT - 1);

    logic [CW-1:0] cnt, cnt_n;
    state_t state_n;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= SHOW_D0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            SHOW_D0:  state_n = (cnt == SHOW_END) ? BLANK_D0 : SHOW_D0;
            BLANK_D0: state_n = (cnt == SLOT_END) ? SHOW_D1 : BLANK_D0;
            SHOW_D1:  state_n = (cnt == SHOW_END) ? BLANK_D1 : SHOW_D1;
            default:  state_n = (cnt == SLOT_END) ? SHOW_D0 : BLANK_D1;
        endcase
        if (cnt == SLOT_END) cnt_n = '0;
    end

    assign chip_sel_mux = (state == SHOW_D0) || (state == BLANK_D0);
endmodule

// File: rtl/ssd_entry_mux_driver.sv
// ssd_entry_mux_driver: keypad entry registers plus manual / multiplexed seven-segment drive.
// Define SSD_BLANK_EMPTY_EN to keep digits dark until they have been written.
module ssd_entry_mux_driver
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DIGIT_HZ = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       sel_toggle,
    input  logic       mode,
    input  logic       clear,
    output logic [6:0] seg,
    output logic       chip_sel,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       entry_ptr
);
    localparam int SLOT = CLK_FREQ / DIGIT_HZ;

    logic [3:0] last_key;
    logic       manual_sel, chip_sel_mux, show0, show1, show_key;
    logic [6:0] seg_next;
    state_t     state;

    ssd_refresh_fsm #(.SLOT(SLOT), .BLANK_CYCLES(BLANK_CYCLES)) u_fsm (
        .clk(clk),
        .rst(rst),
        .enable(mode),
        .state(state),
        .chip_sel_mux(chip_sel_mux)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            digit0     <= '0;
            digit1     <= '0;
            last_key   <= '0;
            entry_ptr  <= 1'b0;
            manual_sel <= 1'b1;
        end else begin
            if (clear) begin
                digit0    <= '0;
                digit1    <= '0;
                last_key  <= '0;
                entry_ptr <= 1'b0;
            end else if (key_valid) begin
                if (entry_ptr) digit1 <= key_code;
                else digit0 <= key_code;
                last_key  <= key_code;
                entry_ptr <= ~entry_ptr;
            end
            if (sel_toggle && !mode) manual_sel <= ~manual_sel;
        end
    end

`ifdef SSD_BLANK_EMPTY_EN
    logic v0, v1;
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (key_valid) begin
            v0 <= v0 | ~entry_ptr;
            v1 <= v1 | entry_ptr;
        end
    end
    // last_key is only meaningful once some digit has been written
    assign show0    = v0;
    assign show1    = v1;
    assign show_key = v0 | v1;
`else
    assign show0    = 1'b1;
    assign show1    = 1'b1;
    assign show_key = 1'b1;
`endif

    always_comb begin
        seg_next = !mode ? (show_key ? hex_to_seg(last_key) : SEG_BLANK) :
                   (state == SHOW_D0 && show0) ? hex_to_seg(digit0) :
                   (state == SHOW_D1 && show1) ? hex_to_seg(digit1) : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg      <= SEG_BLANK;
            chip_sel <= 1'b1;
        end else begin
            seg      <= seg_next;
            chip_sel <= mode ? chip_sel_mux : manual_sel;
        end
    end
endmodule

// File: tb/tb_ssd_entry_mux_driver.sv
// tb_ssd_entry_mux_driver: scoreboard bench, SLOT=10 and BLANK_CYCLES=2, one expected
// {seg, chip_sel, digit0, digit1, entry_ptr} word queued per driven cycle.
module tb_ssd_entry_mux_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic       sel_toggle = 1'b0;
    logic       mode = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic       chip_sel;
    logic [3:0] digit0, digit1;
    logic       entry_ptr;

    typedef struct {
        string       tag;
        logic [16:0] v;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    logic       ghost_chk = 1'b0;
    logic       prev_cs = 1'b1;
    logic [6:0] prev_seg = '0;
    logic [6:0] g [16];
    logic [6:0] z;

    ssd_entry_mux_driver #(.CLK_FREQ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2)) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .sel_toggle(sel_toggle),
        .mode(mode),
        .clear(clear),
        .seg(seg),
        .chip_sel(chip_sel),
        .digit0(digit0),
        .digit1(digit1),
        .entry_ptr(entry_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b required %b", tag, got, want);
        end
    endtask

    task automatic tick(input string tag, input logic [6:0] s, input logic cs,
                        input logic [3:0] a, input logic [3:0] b, input logic p);
        exp_t e;
        e.tag = tag;
        e.v   = {s, cs, a, b, p};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(e.tag, {seg, chip_sel, digit0, digit1, entry_ptr}, e.v);
        if (ghost_chk && chip_sel !== prev_cs) check("noghost", {10'd0, prev_seg}, 17'd0);
        prev_cs    = chip_sel;
        prev_seg   = seg;
        key_valid  = 1'b0;
        sel_toggle = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
    endtask

    initial begin
        g = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
              7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
`ifdef SSD_BLANK_EMPTY_EN
        z = 7'b0;
`else
        z = 7'b1111110;
`endif
        tick("rst0", 0, 1, 0, 0, 0);
        tick("rst1", 0, 1, 0, 0, 0);
        rst = 1'b0;
        tick("idle_m0", z, 1, 0, 0, 0);
        key(3); tick("key3", z, 1, 3, 0, 1);
        key(7); tick("key7", g[3], 1, 3, 7, 0);
        tick("show7", g[7], 1, 3, 7, 0);
        key(9); tick("key9_wrap", g[7], 1, 9, 7, 1);
        tick("show9", g[9], 1, 9, 7, 1);
        clear = 1'b1; tick("clear", g[9], 1, 0, 0, 0);
        key(3); tick("rekey3", z, 1, 3, 0, 1);
        key(7); tick("rekey7", g[3], 1, 3, 7, 0);
        mode = 1'b1;
        ghost_chk = 1'b1;
        for (int k = 0; k < 58; k++) begin
            int ph;
            ph = k % 20;
            if (ph < 8) tick($sformatf("m1_%0d", k), g[3], 1, 3, 7, 0);
            else if (ph < 10) tick($sformatf("m1_%0d", k), 0, 1, 3, 7, 0);
            else if (ph < 18) tick($sformatf("m1_%0d", k), g[7], 0, 3, 7, 0);
            else tick($sformatf("m1_%0d", k), 0, 0, 3, 7, 0);
        end
        ghost_chk = 1'b0;
        rst = 1'b1;
        key(5);
        tick("rst_blank_d1", 0, 1, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) tick($sformatf("post_rst_%0d", k), z, 1, 0, 0, 0);
            else if (k < 10) tick($sformatf("post_rst_%0d", k), 0, 1, 0, 0, 0);
            else tick($sformatf("post_rst_%0d", k), z, 0, 0, 0, 0);
        end
        mode = 1'b0;
        tick("m0_back", z, 1, 0, 0, 0);
        key(4'hA); tick("keyA", z, 1, 4'hA, 0, 1);
        sel_toggle = 1'b1; tick("toggle", g[10], 1, 4'hA, 0, 1);
        tick("toggle_vis", g[10], 0, 4'hA, 0, 1);
        tick("toggle_hold", g[10], 0, 4'hA, 0, 1);
        mode = 1'b1;
        sel_toggle = 1'b1; tick("m1_ignore_tog", g[10], 1, 4'hA, 0, 1);
        mode = 1'b0;
        tick("m1_to_m0", g[10], 0, 4'hA, 0, 1);
        clear = 1'b1; key(5); tick("clear_wins", g[10], 0, 0, 0, 0);
        tick("clear_seg", z, 0, 0, 0, 0);
        mode = 1'b1;
        tick("m1_d0_empty", z, 1, 0, 0, 0);
        key(8); tick("m1_live_key", z, 1, 8, 0, 1);
        tick("m1_live_seg", g[8], 1, 8, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
